// File: rtl/bp_update_queue.sv
// Commit-order queue for resolved conditional branches. Accepts up to two outcomes
// per cycle from the dual-wide commit stage and drains one per cycle to the gshare updater.
module bp_update_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_valid_a,
  input  logic [PC_W-1:0]          br_pc_a,
  input  logic                     br_taken_a,
  input  logic                     br_valid_b,
  input  logic [PC_W-1:0]          br_pc_b,
  input  logic                     br_taken_b,
  output logic                     in_ready,
  input  logic                     upd_stall,
  output logic                     wr_en,
  output logic [PC_W-1:0]          orig_pc,
  output logic                     is_taken,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so a full queue is distinguishable from empty.
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;
  logic            overflow_q, overflow_d;

  logic [PC_W-1:0] pc_mem_q    [DEPTH];
  logic            taken_mem_q [DEPTH];

  logic            empty;
  logic            push_req;
  logic            push_ok;
  logic            wr0_en, wr1_en;
  logic [AW-1:0]   idx0, idx1, rd_idx;
  logic [PC_W-1:0] slot0_pc;
  logic            slot0_taken;
  logic [PW-1:0]   n_acc;

  assign count    = wp_q - rp_q;
  assign empty    = (count == '0);
  assign in_ready = (count <= PW'(DEPTH - 2));
  assign overflow = overflow_q;

  assign rd_idx   = rp_q[AW-1:0];
  assign wr_en    = !empty && !upd_stall;
  assign orig_pc  = pc_mem_q[rd_idx];
  assign is_taken = taken_mem_q[rd_idx];

  assign idx0 = wp_q[AW-1:0];
  assign idx1 = idx0 + AW'(1);

  always_comb begin
    push_req    = br_valid_a | br_valid_b;
    push_ok     = push_req & in_ready;
    wr0_en      = push_ok;
    wr1_en      = push_ok & br_valid_a & br_valid_b;
    // A lone b-valid packs into the first slot so the queue never holds a hole.
    slot0_pc    = br_valid_a ? br_pc_a    : br_pc_b;
    slot0_taken = br_valid_a ? br_taken_a : br_taken_b;
    n_acc       = '0;
    if (push_ok) begin
      n_acc = (br_valid_a && br_valid_b) ? PW'(2) : PW'(1);
    end
    wp_d       = wp_q + n_acc;
    rp_d       = rp_q + {{(PW-1){1'b0}}, wr_en};
    overflow_d = overflow_q | (push_req & ~in_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr0_en) begin
        pc_mem_q[idx0]    <= slot0_pc;
        taken_mem_q[idx0] <= slot0_taken;
      end
      if (wr1_en) begin
        pc_mem_q[idx1]    <= br_pc_b;
        taken_mem_q[idx1] <= br_taken_b;
      end
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: reset, latency, ordering, back-pressure,
// overflow, wrap-around and stall hold, each checked against hand-computed values.
module tb_bp_update_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              br_valid_a, br_taken_a, br_valid_b, br_taken_b;
  logic [PC_W-1:0]   br_pc_a, br_pc_b;
  logic              in_ready, upd_stall, wr_en, is_taken, overflow;
  logic [PC_W-1:0]   orig_pc;
  logic [$clog2(DEPTH):0] count;

  int tests = 0;
  int fails = 0;

  bp_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .br_valid_a(br_valid_a), .br_pc_a(br_pc_a), .br_taken_a(br_taken_a),
    .br_valid_b(br_valid_b), .br_pc_b(br_pc_b), .br_taken_b(br_taken_b),
    .in_ready(in_ready), .upd_stall(upd_stall),
    .wr_en(wr_en), .orig_pc(orig_pc), .is_taken(is_taken),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_push();
    br_valid_a = 1'b0; br_pc_a = '0; br_taken_a = 1'b0;
    br_valid_b = 1'b0; br_pc_b = '0; br_taken_b = 1'b0;
  endtask

  task automatic test_reset();
    clear_push();
    upd_stall = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_single_push();
    br_valid_a = 1'b1; br_pc_a = 32'h0000_1004; br_taken_a = 1'b1;
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL single_no_bypass got %b exp 0", wr_en); end
    step();
    clear_push();
    #1;
    $display("[TB] single pop pc=%h taken=%b wr_en=%b", orig_pc, is_taken, wr_en);
    tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL single_wr_en got %b exp 1", wr_en); end
    tests++; if (orig_pc !== 32'h0000_1004) begin fails++; $display("FAIL single_pc got %h exp 00001004", orig_pc); end
    tests++; if (is_taken !== 1'b1) begin fails++; $display("FAIL single_taken got %b exp 1", is_taken); end
    step();
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL single_after_wr_en got %b exp 0", wr_en); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL single_after_count got %0d exp 0", count); end
  endtask

  task automatic test_dual_order();
    logic [PC_W-1:0] exp_pc [3];
    logic            exp_t  [3];
    exp_pc[0] = 32'h100; exp_t[0] = 1'b0;
    exp_pc[1] = 32'h104; exp_t[1] = 1'b1;
    exp_pc[2] = 32'h200; exp_t[2] = 1'b1;
    br_valid_a = 1'b1; br_pc_a = 32'h100; br_taken_a = 1'b0;
    br_valid_b = 1'b1; br_pc_b = 32'h104; br_taken_b = 1'b1;
    step();
    clear_push();
    br_valid_b = 1'b1; br_pc_b = 32'h200; br_taken_b = 1'b1;
    #1;
    tests++; if (count !== 4'd2) begin fails++; $display("FAIL dual_count got %0d exp 2", count); end
    for (int i = 0; i < 3; i++) begin
      $display("[TB] dual pop %0d pc=%h taken=%b wr_en=%b", i, orig_pc, is_taken, wr_en);
      tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL dual_wr_en[%0d] got %b exp 1", i, wr_en); end
      tests++; if (orig_pc !== exp_pc[i]) begin fails++; $display("FAIL dual_pc[%0d] got %h exp %h", i, orig_pc, exp_pc[i]); end
      tests++; if (is_taken !== exp_t[i]) begin fails++; $display("FAIL dual_taken[%0d] got %b exp %b", i, is_taken, exp_t[i]); end
      step();
      clear_push();
      #1;
    end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL dual_drained got wr_en %b exp 0", wr_en); end
  endtask

  task automatic test_fill_backpressure();
    logic [PC_W-1:0] exp_pc [8];
    logic            exp_t  [8];
    upd_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc[2*i]   = 32'h400 + 32'(8*i);     exp_t[2*i]   = 1'(i % 2);
      exp_pc[2*i+1] = 32'h400 + 32'(8*i + 4); exp_t[2*i+1] = 1'((i + 1) % 2);
      br_valid_a = 1'b1; br_pc_a = exp_pc[2*i];   br_taken_a = exp_t[2*i];
      br_valid_b = 1'b1; br_pc_b = exp_pc[2*i+1]; br_taken_b = exp_t[2*i+1];
      step();
      clear_push();
      #1;
      tests++; if (count !== 4'(2*i + 2)) begin fails++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, 2*i + 2); end
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL fill_stall_wr_en[%0d] got %b exp 0", i, wr_en); end
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL pre_overflow got %b exp 0", overflow); end
    br_valid_a = 1'b1; br_pc_a = 32'hDEAD_0000; br_taken_a = 1'b1;
    br_valid_b = 1'b1; br_pc_b = 32'hDEAD_0004; br_taken_b = 1'b1;
    step();
    clear_push();
    #1;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set got %b exp 1", overflow); end
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL overflow_count got %0d exp 8", count); end
    upd_stall = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      $display("[TB] drain pop %0d pc=%h taken=%b wr_en=%b", i, orig_pc, is_taken, wr_en);
      tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL drain_wr_en[%0d] got %b exp 1", i, wr_en); end
      tests++; if (orig_pc !== exp_pc[i]) begin fails++; $display("FAIL drain_pc[%0d] got %h exp %h", i, orig_pc, exp_pc[i]); end
      tests++; if (is_taken !== exp_t[i]) begin fails++; $display("FAIL drain_taken[%0d] got %b exp %b", i, is_taken, exp_t[i]); end
      step();
      if (i == 0) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL count7_in_ready got %b exp 0", in_ready); end
      end
      if (i == 1) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL count6_in_ready got %b exp 1", in_ready); end
      end
    end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL drain_count got %0d exp 0", count); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_reset_midqueue();
    upd_stall = 1'b1;
    br_valid_a = 1'b1; br_pc_a = 32'h700; br_valid_b = 1'b1; br_pc_b = 32'h704;
    step();
    br_pc_a = 32'h708; br_pc_b = 32'h70C;
    step();
    br_valid_b = 1'b0; br_pc_a = 32'h710;
    step();
    clear_push();
    #1;
    tests++; if (count !== 4'd5) begin fails++; $display("FAIL midq_count got %0d exp 5", count); end
    rst = 1'b1; upd_stall = 1'b0;
    br_valid_a = 1'b1; br_pc_a = 32'h7FF;
    step();
    rst = 1'b0;
    clear_push();
    #1;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL midq_rst_count got %0d exp 0", count); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL midq_rst_wr_en got %b exp 0", wr_en); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL midq_rst_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_concurrent_wrap();
    logic [PC_W-1:0] q_pc [$];
    logic            q_t  [$];
    logic [PC_W-1:0] epc;
    logic            et;
    upd_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      br_valid_a = 1'b1; br_pc_a = 32'h5000 + 32'(4*i); br_taken_a = 1'(i % 2);
      q_pc.push_back(br_pc_a); q_t.push_back(br_taken_a);
      step();
    end
    clear_push();
    upd_stall = 1'b0;
    for (int i = 3; i < 23; i++) begin
      br_valid_a = 1'b1; br_pc_a = 32'h5000 + 32'(4*i); br_taken_a = 1'((i / 3) % 2);
      #1;
      epc = q_pc.pop_front(); et = q_t.pop_front();
      q_pc.push_back(br_pc_a); q_t.push_back(br_taken_a);
      $display("[TB] stream pop %0d pc=%h taken=%b count=%0d", i - 3, orig_pc, is_taken, count);
      tests++; if (count !== 4'd3) begin fails++; $display("FAIL stream_count[%0d] got %0d exp 3", i, count); end
      tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL stream_wr_en[%0d] got %b exp 1", i, wr_en); end
      tests++; if (orig_pc !== epc) begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", i, orig_pc, epc); end
      tests++; if (is_taken !== et) begin fails++; $display("FAIL stream_taken[%0d] got %b exp %b", i, is_taken, et); end
      step();
    end
    clear_push();
    #1;
    while (q_pc.size() > 0) begin
      epc = q_pc.pop_front(); et = q_t.pop_front();
      tests++; if (orig_pc !== epc || is_taken !== et || wr_en !== 1'b1) begin
        fails++; $display("FAIL stream_tail got %h/%b/%b exp %h/%b/1", orig_pc, is_taken, wr_en, epc, et);
      end
      step();
    end
    // 23 entries consumed: write index now 7, so the next dual push straddles 7 -> 0.
    br_valid_a = 1'b1; br_pc_a = 32'h6000; br_taken_a = 1'b1;
    br_valid_b = 1'b1; br_pc_b = 32'h6004; br_taken_b = 1'b0;
    step();
    clear_push();
    #1;
    $display("[TB] straddle pop pc=%h taken=%b", orig_pc, is_taken);
    tests++; if (orig_pc !== 32'h6000 || is_taken !== 1'b1 || wr_en !== 1'b1) begin
      fails++; $display("FAIL straddle_a got %h/%b/%b exp 00006000/1/1", orig_pc, is_taken, wr_en);
    end
    step();
    $display("[TB] straddle pop pc=%h taken=%b", orig_pc, is_taken);
    tests++; if (orig_pc !== 32'h6004 || is_taken !== 1'b0 || wr_en !== 1'b1) begin
      fails++; $display("FAIL straddle_b got %h/%b/%b exp 00006004/0/1", orig_pc, is_taken, wr_en);
    end
    step();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL straddle_count got %0d exp 0", count); end
  endtask

  task automatic test_stall_hold();
    br_valid_a = 1'b1; br_pc_a = 32'h300; br_taken_a = 1'b1;
    step();
    clear_push();
    upd_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      $display("[TB] stall cycle %0d pc=%h wr_en=%b", i, orig_pc, wr_en);
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL stall_wr_en[%0d] got %b exp 0", i, wr_en); end
      tests++; if (orig_pc !== 32'h300 || is_taken !== 1'b1) begin
        fails++; $display("FAIL stall_head[%0d] got %h/%b exp 00000300/1", i, orig_pc, is_taken);
      end
      step();
    end
    upd_stall = 1'b0;
    #1;
    tests++; if (wr_en !== 1'b1 || orig_pc !== 32'h300) begin
      fails++; $display("FAIL stall_release got %b/%h exp 1/00000300", wr_en, orig_pc);
    end
    step();
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL stall_once_wr_en got %b exp 0", wr_en); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL stall_once_count got %0d exp 0", count); end
  endtask

  initial begin
    rst = 1'b1;
    upd_stall = 1'b0;
    clear_push();
    test_reset();
    test_single_push();
    test_dual_order();
    test_fill_backpressure();
    test_reset_midqueue();
    test_concurrent_wrap();
    test_stall_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
